// File: rtl/traffic_pkg.sv
// Shared encodings for the four-way intersection scheduler: light codes,
// approach directions and the phase state encoding.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'd0;
    localparam logic [2:0] YELLOW = 3'd1;
    localparam logic [2:0] GREEN  = 3'd2;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

endpackage

// File: rtl/rr_dir_select.sv
// Combinational round-robin picker: first pending approach after cur, in
// order cur+1, cur+2, cur+3; falls back to N when nothing is pending.
module rr_dir_select
    import traffic_pkg::*;
(
    input  logic [3:0] pend,
    input  logic [1:0] cur,
    output logic [1:0] nxt,
    output logic       any_valid
);

    logic [1:0] cand [1:3];
    logic [3:1] hit;

    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : g_cand
            assign cand[gi] = cur + 2'(gi);
            assign hit[gi]  = pend[cand[gi]];
        end
    endgenerate

    // cur itself is never a candidate, so its own pend bit cannot win.
    always_comb begin
        nxt       = DIR_N;
        any_valid = 1'b1;
        if (hit[1]) begin
            nxt = cand[1];
        end else if (hit[2]) begin
            nxt = cand[2];
        end else if (hit[3]) begin
            nxt = cand[3];
        end else begin
            any_valid = 1'b0;
        end
    end

endmodule

// File: rtl/four_way_phase_scheduler.sv
// Sensor-driven round-robin scheduler for a four-way intersection: one green
// at a time, each hand-over runs GREEN -> YELLOW -> ALL-RED.
module four_way_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 5,
    parameter int MAX_GREEN  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic       CLOCK,
    input  logic       CLEAR,
    input  logic [3:0] CAR_SENSE,
    output logic [2:0] SIG_N,
    output logic [2:0] SIG_E,
    output logic [2:0] SIG_S,
    output logic [2:0] SIG_W,
    output logic [1:0] GRANT_DIR,
    output logic [3:0] PEND
);

    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);

    phase_t           phase_reg, phase_next;
    logic [1:0]       cur_reg, cur_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       pend_reg, pend_next;

    logic       grant;
    logic       other_pend;
    logic       go_yellow;
    logic [1:0] rr_nxt;
    logic       rr_any;

    rr_dir_select u_rr (
        .pend      (pend_reg),
        .cur       (cur_reg),
        .nxt       (rr_nxt),
        .any_valid (rr_any)
    );

    assign other_pend = |(pend_reg & ~(4'b0001 << cur_reg));

    // A busy current road may stretch its green up to the maximum bound.
    assign go_yellow = (cnt_reg >= MIN_LAST) && other_pend &&
                       (!CAR_SENSE[cur_reg] || (cnt_reg >= MAX_LAST));

    always_comb begin
        phase_next = phase_reg;
        cur_next   = cur_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        grant      = 1'b0;
        case (phase_reg)
            PH_GREEN: begin
                if (go_yellow) begin
                    phase_next = PH_YELLOW;
                    cnt_next   = '0;
                end else if (cnt_reg >= MAX_LAST) begin
                    cnt_next = MAX_LAST;
                end
            end
            PH_YELLOW: begin
                if (cnt_reg == YELLOW_LAST) begin
                    phase_next = PH_ALLRED;
                    cnt_next   = '0;
                end
            end
            PH_ALLRED: begin
                if (cnt_reg == ALLRED_LAST) begin
                    phase_next = PH_GREEN;
                    cnt_next   = '0;
                    grant      = 1'b1;
                    cur_next   = rr_any ? rr_nxt : DIR_N;
                end
            end
            default: begin
                phase_next = PH_GREEN;
                cur_next   = DIR_N;
                cnt_next   = '0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pend
            assign pend_next[gi] =
                (grant && (cur_next == 2'(gi)))                        ? 1'b0 :
                (CAR_SENSE[gi] &&
                 !((phase_reg == PH_GREEN) && (cur_reg == 2'(gi))))    ? 1'b1 :
                                                                         pend_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            phase_reg <= PH_GREEN;
            cur_reg   <= DIR_N;
            cnt_reg   <= '0;
            pend_reg  <= '0;
        end else begin
            phase_reg <= phase_next;
            cur_reg   <= cur_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
        end
    end

    logic [2:0] sig [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sig
            assign sig[gi] = (cur_reg != 2'(gi))      ? RED    :
                             (phase_reg == PH_GREEN)  ? GREEN  :
                             (phase_reg == PH_YELLOW) ? YELLOW : RED;
        end
    endgenerate

    assign SIG_N     = sig[0];
    assign SIG_E     = sig[1];
    assign SIG_S     = sig[2];
    assign SIG_W     = sig[3];
    assign GRANT_DIR = cur_reg;
    assign PEND      = pend_reg;

endmodule

// File: tb/tb_four_way_phase_scheduler.sv
// Scoreboard bench: the driver pushes expected lights from a behavioural
// intersection model; a monitor pops and compares every cycle.
module tb_four_way_phase_scheduler;

    localparam int MIN_G = 5;
    localparam int MAX_G = 10;
    localparam int YEL   = 3;
    localparam int AR    = 2;

    logic       CLOCK = 1'b0;
    logic       CLEAR = 1'b1;
    logic [3:0] CAR_SENSE = 4'd0;
    logic [2:0] SIG_N, SIG_E, SIG_S, SIG_W;
    logic [1:0] GRANT_DIR;
    logic [3:0] PEND;

    four_way_phase_scheduler #(
        .MIN_GREEN  (MIN_G),
        .MAX_GREEN  (MAX_G),
        .YELLOW_CYC (YEL),
        .ALLRED_CYC (AR),
        .CNT_W      (4)
    ) dut (
        .CLOCK     (CLOCK),
        .CLEAR     (CLEAR),
        .CAR_SENSE (CAR_SENSE),
        .SIG_N     (SIG_N),
        .SIG_E     (SIG_E),
        .SIG_S     (SIG_S),
        .SIG_W     (SIG_W),
        .GRANT_DIR (GRANT_DIR),
        .PEND      (PEND)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int         id;
        logic [2:0] sig [4];
        logic [1:0] grant;
        logic [3:0] pend;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;
    bit   drv_done = 0;

    // Intersection model: which road owns the lights, what it is showing,
    // how long it has shown it, and who is queued.
    int       m_show;   // 0 green, 1 yellow, 2 all red
    int       m_age;    // cycles already spent in the current showing
    int       m_owner;
    bit [3:0] m_wait;

    function automatic void m_reset();
        m_show  = 0;
        m_age   = 0;
        m_owner = 0;
        m_wait  = 4'd0;
    endfunction

    function automatic void m_step(input logic [3:0] s);
        int  shown;
        bit  others;
        int  granted;
        shown   = m_age + 1;
        granted = -1;
        others  = 0;
        for (int j = 0; j < 4; j++)
            if (j != m_owner && m_wait[j]) others = 1;
        for (int i = 0; i < 4; i++)
            if (s[i] && !(m_show == 0 && m_owner == i)) m_wait[i] = 1;
        if (m_show == 0) begin
            m_age = shown;
            if (shown >= MIN_G && others && (!s[m_owner] || shown >= MAX_G)) begin
                m_show = 1;
                m_age  = 0;
            end
        end else if (m_show == 1) begin
            m_age = shown;
            if (shown == YEL) begin
                m_show = 2;
                m_age  = 0;
            end
        end else begin
            m_age = shown;
            if (shown == AR) begin
                int pick;
                pick = 0;
                for (int k = 3; k >= 1; k--)
                    if (m_wait_before(k)) pick = (m_owner + k) % 4;
                m_show  = 0;
                m_age   = 0;
                m_owner = pick;
                granted = pick;
            end
        end
        if (granted >= 0) m_wait[granted] = 0;
    endfunction

    // Queue snapshot taken before this cycle's sensors were latched.
    bit [3:0] m_wait_prev;
    function automatic bit m_wait_before(input int k);
        return m_wait_prev[(m_owner + k) % 4];
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        e.id = txn;
        for (int i = 0; i < 4; i++) begin
            if (i != m_owner || m_show == 2) e.sig[i] = 3'd0;
            else if (m_show == 0)             e.sig[i] = 3'd2;
            else                              e.sig[i] = 3'd1;
        end
        e.grant = 2'(m_owner);
        e.pend  = m_wait;
        return e;
    endfunction

    task automatic step(input logic [3:0] s, input bit clr);
        @(posedge CLOCK);
        #1;
        if (clr) begin
            CLEAR = 1'b1;
            m_reset();
        end else begin
            CLEAR = 1'b0;
        end
        CAR_SENSE = s;
        exp_q.push_back(m_expect());
        txn++;
        if (!clr) begin
            m_wait_prev = m_wait;
            m_step(s);
        end
    endtask

    task automatic chk(input string nm, input int id, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s txn=%0d got=%0d expected=%0d", nm, id, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLOCK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sig_n", e.id, int'(SIG_N), int'(e.sig[0]));
                chk("sig_e", e.id, int'(SIG_E), int'(e.sig[1]));
                chk("sig_s", e.id, int'(SIG_S), int'(e.sig[2]));
                chk("sig_w", e.id, int'(SIG_W), int'(e.sig[3]));
                chk("grant", e.id, int'(GRANT_DIR), int'(e.grant));
                chk("pend",  e.id, int'(PEND), int'(e.pend));
                $display("txn %0d clr=%0d sense=%b sig=%0d%0d%0d%0d grant=%0d pend=%b",
                         e.id, CLEAR, CAR_SENSE, SIG_N, SIG_E, SIG_S, SIG_W,
                         GRANT_DIR, PEND);
            end
        end
    end

    initial begin : driver
        m_reset();
        m_wait_prev = 4'd0;

        // Idle: N parks green.
        step(4'd0, 1);
        repeat (50) step(4'd0, 0);

        // Single E pulse at cycle 2.
        step(4'd0, 1);
        step(4'd0, 0);
        step(4'd0, 0);
        step(4'b0010, 0);
        repeat (20) step(4'd0, 0);

        // N and E both busy: max-green stretching both ways.
        step(4'd0, 1);
        repeat (40) step(4'b0011, 0);

        // W green, then N/E/S queue up together.
        step(4'd0, 1);
        step(4'b1000, 0);
        for (int i = 0; i < 40; i++) begin
            if (m_show == 0 && m_owner == 3) break;
            step(4'd0, 0);
        end
        step(4'b0111, 0);
        repeat (60) step(4'd0, 0);

        // Reset while E is yellow.
        step(4'd0, 1);
        step(4'b0010, 0);
        for (int i = 0; i < 40; i++) begin
            if (m_show == 0 && m_owner == 1) break;
            step(4'd0, 0);
        end
        step(4'b0001, 0);
        for (int i = 0; i < 40; i++) begin
            if (m_show == 1 && m_owner == 1) break;
            step(4'd0, 0);
        end
        step(4'd0, 0);
        step(4'd0, 1);
        repeat (5) step(4'd0, 0);

        // Current road busy alone: green held, nothing latched.
        step(4'd0, 1);
        repeat (120) step(4'b0001, 0);

        // Random traffic with occasional resets.
        step(4'd0, 1);
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] s;
            for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 6) == 0);
            step(s, ($urandom_range(0, 249) == 0));
        end

        drv_done = 1;
    end

    initial begin : finisher
        wait (drv_done);
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLOCK);
        end
        @(posedge CLOCK);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
